// File: rtl/lfsr_checker.sv
// Self-synchronizing checker for a Fibonacci LFSR bit stream.
// Predicts each bit from history, locks on a run of hits, counts errors.
module lfsr_checker #(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] TAPS        = 2'b11,
    parameter int               LOCK_COUNT  = 4,
    parameter int               UNLOCK_ERRS = 4,
    parameter int               ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int FW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FILL,
        SYNC,
        LOCKED
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] hist, hist_n;
    logic [FW-1:0]    fill_cnt, fill_n;
    logic [7:0]       match_cnt, match_n;
    logic [7:0]       miss_cnt, miss_n;
    logic [ERR_W-1:0] cnt_n;
    logic             err_n;
    logic             pred;
    logic             good;

    assign pred = ^(hist & TAPS);
    // An all-zero history matches a zero bit trivially; treat it as bad
    // so a stuck-at-0 line can never acquire lock.
    assign good = (bit_in == pred) && (hist != '0);

    always_comb begin
        state_n = state;
        hist_n  = hist;
        fill_n  = fill_cnt;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        err_n   = 1'b0;
        cnt_n   = err_clr ? '0 : err_count;
        if (bit_valid) begin
            hist_n = {bit_in, hist[WIDTH-1:1]};
            unique case (state)
                FILL: begin
                    fill_n = fill_cnt + FW'(1);
                    if (fill_cnt == FW'(WIDTH - 1)) begin
                        state_n = SYNC;
                        match_n = '0;
                    end
                end
                SYNC: begin
                    if (good) begin
                        match_n = match_cnt + 8'd1;
                        if (match_cnt == 8'(LOCK_COUNT - 1)) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_n = '0;
                    end else begin
                        err_n  = 1'b1;
                        miss_n = miss_cnt + 8'd1;
                        if (!err_clr && err_count != {ERR_W{1'b1}})
                            cnt_n = err_count + ERR_W'(1);
                        if (miss_cnt == 8'(UNLOCK_ERRS - 1)) begin
                            state_n = SYNC;
                            match_n = '0;
                            miss_n  = '0;
                        end
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill_cnt  <= fill_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            locked    <= (state_n == LOCKED);
            err       <= err_n;
            err_count <= cnt_n;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: vector table, corner sequences, random vs model.
module tb_lfsr_checker;

    localparam int W   = 2;
    localparam int LC  = 4;
    localparam int UE  = 4;
    localparam int MAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       locked, err;
    logic [7:0] err_count;
    logic       locked2, err2;
    logic [1:0] err_count2;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_checker dut (
        .clk(clk), .reset(reset), .bit_in(bit_in),
        .bit_valid(bit_valid), .err_clr(err_clr),
        .locked(locked), .err(err), .err_count(err_count)
    );

    lfsr_checker #(.UNLOCK_ERRS(8), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .bit_in(bit_in),
        .bit_valid(bit_valid), .err_clr(err_clr),
        .locked(locked2), .err(err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic gbit(input int i);
        return (i % 3) != 2;
    endfunction

    task automatic cycle(input logic b, input logic v, input logic c);
        @(negedge clk);
        bit_in    = b;
        bit_valid = v;
        err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bit_valid = 1'b0;
        err_clr   = 1'b0;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lock_up();
        for (int i = 0; i < W + LC; i++) cycle(gbit(i), 1'b1, 1'b0);
        chk("lock_up", locked, 1);
    endtask

    // Reference model: history as a queue of received bits, plain counters.
    int   hq[$];
    int   m_seen, m_match, m_miss, m_cnt;
    logic m_locked, m_err;

    task automatic model_reset();
        hq = {};
        for (int i = 0; i < W; i++) hq.push_back(0);
        m_seen = 0; m_match = 0; m_miss = 0; m_cnt = 0;
        m_locked = 0; m_err = 0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic c);
        int p, nz;
        logic [W-1:0] taps;
        bit good;
        taps  = 2'b11;
        m_err = 0;
        if (c) m_cnt = 0;
        if (v) begin
            p = 0; nz = 0;
            for (int i = 0; i < W; i++) begin
                if (taps[i]) p = p ^ hq[i];
                if (hq[i] != 0) nz = 1;
            end
            good = (int'(b) == p) && (nz != 0);
            if (m_seen < W) begin
                m_seen++;
            end else if (m_locked) begin
                if (good) m_miss = 0;
                else begin
                    m_err = 1;
                    if (!c && m_cnt < MAX) m_cnt++;
                    m_miss++;
                    if (m_miss == UE) begin
                        m_locked = 0;
                        m_match  = 0;
                    end
                end
            end else begin
                if (good) begin
                    m_match++;
                    if (m_match == LC) begin
                        m_locked = 1;
                        m_miss   = 0;
                    end
                end else m_match = 0;
            end
            hq.push_back(int'(b));
            void'(hq.pop_front());
        end
    endtask

    typedef struct {
        logic       b, v, c;
        logic       l, e;
        logic [7:0] n;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int vc, guard, gp, zb;
        logic b, v, c, fl;

        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 1});
        tbl.push_back('{1, 1, 0, 1, 1, 2});
        tbl.push_back('{0, 1, 0, 1, 1, 3});
        tbl.push_back('{1, 1, 0, 1, 0, 3});
        tbl.push_back('{1, 1, 0, 1, 0, 3});
        tbl.push_back('{0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 1});
        tbl.push_back('{1, 1, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 1});
        tbl.push_back('{1, 1, 0, 1, 0, 1});

        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].b, tbl[i].v, tbl[i].c);
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].l);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].e);
            chk($sformatf("tbl%0d_cnt", i), err_count, tbl[i].n);
        end

        // Stuck-at-0 while locked, then relock on the real stream.
        do_reset();
        lock_up();
        for (int i = 1; i <= 14; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("stuck_locked", locked, i < UE ? 1 : 0);
            chk("stuck_err", err, i <= UE ? 1 : 0);
            chk("stuck_cnt", err_count, i <= UE ? i : UE);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(gbit(i), 1'b1, 1'b0);
            chk("relock_locked", locked, i == 4 ? 1 : 0);
            chk("relock_err", err, 0);
        end

        // Lock index is unaffected by bit_valid gaps.
        do_reset();
        vc = 0;
        guard = 0;
        while (vc < W + LC && guard < 200) begin
            guard++;
            if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, 1'b0);
            else begin
                cycle(gbit(vc), 1'b1, 1'b0);
                vc++;
            end
            chk("gap_locked", locked, vc >= W + LC ? 1 : 0);
        end
        chk("gap_budget", vc, W + LC);
        cycle(1'b0, 1'b1, 1'b1);
        chk("clr_err", err, 1);
        chk("clr_cnt", err_count, 0);

        // Saturation on the narrow-counter instance.
        do_reset();
        lock_up();
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("sat_locked", locked2, 1);
            chk("sat_err", err2, 1);
            chk("sat_cnt", err_count2, i < 3 ? i : 3);
        end

        // Async reset between edges while locked with three errors.
        do_reset();
        lock_up();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("pre_rst_cnt", err_count, 3);
        chk("pre_rst_locked", locked, 1);
        #3 reset = 1'b1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_cnt", err_count, 0);
        chk("async_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < W + LC; i++) begin
            cycle(gbit(i), 1'b1, 1'b0);
            chk("post_rst_locked", locked, i == W + LC - 1 ? 1 : 0);
        end

        // Random stream with flips, zero bursts, gaps and clears.
        do_reset();
        model_reset();
        gp = 0;
        zb = 0;
        for (int k = 0; k < 3000; k++) begin
            v  = ($urandom_range(0, 4) != 0);
            c  = v && ($urandom_range(0, 39) == 0);
            fl = ($urandom_range(0, 29) == 0);
            b  = (zb > 0) ? 1'b0 : (gbit(gp) ^ fl);
            if (v) begin
                gp++;
                if (zb > 0) zb--;
                else if ($urandom_range(0, 149) == 0) zb = $urandom_range(1, 7);
            end
            cycle(b, v, c);
            model_step(b, v, c);
            chk("rnd_locked", locked, m_locked);
            chk("rnd_err", err, m_err);
            chk("rnd_cnt", err_count, m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
